rr_req_collector_32: RTL and testbench

Requester-side companion of the 32-way round-robin arbiter in the Forney datapath. Holds one pending symbol per lane, raises `req_o` toward the arbiter, consumes the returned one-hot `grant_i`, and forwards the granted lane's symbol with its lane index through a small output FIFO to the serial Forney evaluator. It turns 32 independent valid/ready producers into one fairly arbitrated valid/ready stream.

---
 rtl/rr_collect_pkg.sv | 18 +
 rtl/rr_collect_fifo.sv | 81 ++++++++
 rtl/rr_req_collector_32.sv | 138 +++++++++++++
 tb/tb_rr_req_collector_32.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_collect_pkg.sv
// Shared types and constants for the 32-way round-robin request collector.
package rr_collect_pkg;

   localparam int REQ_NB = 32;
   localparam int IDX_W  = $clog2(REQ_NB);
   localparam int DATA_W = 10;

   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
   } fifo_entry_t;

   // Isolates the least significant set bit of a request-wide vector.
   function automatic logic [REQ_NB-1:0] lowest_set(input logic [REQ_NB-1:0] v);
      return v & (~v + REQ_NB'(1));
   endfunction

endpackage

// File: rtl/rr_collect_fifo.sv
// Circular FIFO with wrap-around pointers and an occupancy count output.
// Push while full and pop while empty are ignored.
module rr_collect_fifo #(
   parameter int WIDTH = 15,
   parameter int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic [CNT_W-1:0] cnt_o
);

   localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_C = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push_ok_s, pop_ok_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == LAST_C) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   assign push_ok_s  = push_i & (cnt_q != FULL_C);
   assign pop_ok_s   = pop_i & (cnt_q != {CNT_W{1'b0}});
   assign pop_data_o = mem_q[rd_ptr_q];
   assign cnt_o      = cnt_q;

   // Next pointer and count values.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok_s) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Pointer and count registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_q <= {PTR_W{1'b0}};
         wr_ptr_q <= {PTR_W{1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage array; contents are meaningless while the count is zero.
   always_ff @(posedge clk_i) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/rr_req_collector_32.sv
// Requester side of the 32-way round-robin arbiter: per-lane holding registers,
// request generation, grant consumption and output FIFO. Optional: RR_COLLECT_ERR_CHK_EN.
module rr_req_collector_32
   import rr_collect_pkg::*;
#(
   parameter int OUT_DEPTH = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [REQ_NB-1:0]        lane_valid_i,
   input  logic [REQ_NB*DATA_W-1:0] lane_data_i,
   output logic [REQ_NB-1:0]        lane_ready_o,
   output logic [REQ_NB-1:0]        req_o,
   input  logic [REQ_NB-1:0]        grant_i,
   output logic                     out_valid_o,
   output logic [DATA_W-1:0]        out_data_o,
   output logic [IDX_W-1:0]         out_idx_o,
   input  logic                     out_ready_i,
   output logic                     err_o
);

   localparam int CNT_W = $clog2(OUT_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUT_DEPTH);

   logic [REQ_NB-1:0] pend_q, pend_d;
   logic [DATA_W-1:0] hold_q [REQ_NB];
   logic [REQ_NB-1:0] capture_s, g_s, sel_s;
   logic [IDX_W-1:0]  sel_idx_s;
   logic [CNT_W-1:0]  cnt_s;
   logic              space_s, accept_s, pop_s;
   fifo_entry_t       push_entry_s, head_entry_s;

   // Requests come only from registers so the arbiter loop never closes back onto req_o.
   assign space_s      = (cnt_s < DEPTH_C);
   assign req_o        = pend_q & {REQ_NB{space_s}};
   assign lane_ready_o = ~pend_q;
   assign capture_s    = lane_valid_i & ~pend_q;
   assign g_s          = grant_i & req_o;

`ifdef RR_COLLECT_ERR_CHK_EN
   logic err_q, err_d;
   logic multi_s, stray_s, g_onehot_s;

   assign multi_s    = |(grant_i & (grant_i - REQ_NB'(1)));
   assign stray_s    = |(grant_i & ~req_o);
   assign g_onehot_s = (g_s != {REQ_NB{1'b0}}) && ((g_s & (g_s - REQ_NB'(1))) == {REQ_NB{1'b0}});
   assign sel_s      = g_onehot_s ? g_s : {REQ_NB{1'b0}};
   assign err_o      = err_q;

   // Sticky protocol error; only reset clears it.
   always_comb begin
      err_d = err_q;
      if (multi_s || stray_s) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

   // Error flag register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
`else
   assign sel_s = lowest_set(g_s);
   assign err_o = 1'b0;
`endif

   assign accept_s = |sel_s;

   // One-hot to binary encode of the accepted grant.
   always_comb begin
      sel_idx_s = {IDX_W{1'b0}};
      for (int k = 0; k < REQ_NB; k++) begin
         if (sel_s[k]) begin
            sel_idx_s = sel_idx_s | IDX_W'(k);
         end else begin
            sel_idx_s = sel_idx_s;
         end
      end
   end

   // Pending flags: capture sets, accepted grant clears (never both on one lane).
   always_comb begin
      pend_d = pend_q;
      for (int k = 0; k < REQ_NB; k++) begin
         if (capture_s[k]) begin
            pend_d[k] = 1'b1;
         end else if (sel_s[k]) begin
            pend_d[k] = 1'b0;
         end else begin
            pend_d[k] = pend_q[k];
         end
      end
   end

   // Pending flag and holding registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend_q <= {REQ_NB{1'b0}};
         for (int k = 0; k < REQ_NB; k++) begin
            hold_q[k] <= {DATA_W{1'b0}};
         end
      end else begin
         pend_q <= pend_d;
         for (int k = 0; k < REQ_NB; k++) begin
            if (capture_s[k]) begin
               hold_q[k] <= lane_data_i[k*DATA_W +: DATA_W];
            end
         end
      end
   end

   assign push_entry_s.idx  = sel_idx_s;
   assign push_entry_s.data = hold_q[sel_idx_s];
   assign out_valid_o       = (cnt_s != {CNT_W{1'b0}});
   assign pop_s             = out_valid_o & out_ready_i;
   assign out_data_o        = head_entry_s.data;
   assign out_idx_o         = head_entry_s.idx;

   rr_collect_fifo #(
      .WIDTH ($bits(fifo_entry_t)),
      .DEPTH (OUT_DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (accept_s),
      .push_data_i (push_entry_s),
      .pop_i       (pop_s),
      .pop_data_o  (head_entry_s),
      .cnt_o       (cnt_s)
   );

endmodule

// File: tb/tb_rr_req_collector_32.sv
// Directed self-checking bench for rr_req_collector_32 with a behavioural
// round-robin arbiter; honours RR_COLLECT_ERR_CHK_EN like the design.
module tb_rr_req_collector_32;
   import rr_collect_pkg::*;

`ifdef RR_COLLECT_ERR_CHK_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif
   localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

   logic                     clk_i = 1'b0;
   logic                     rst_i;
   logic [REQ_NB-1:0]        lane_valid_i;
   logic [REQ_NB*DATA_W-1:0] lane_data_i;
   logic [REQ_NB-1:0]        lane_ready_o;
   logic [REQ_NB-1:0]        req_o;
   logic [REQ_NB-1:0]        grant_i;
   logic                     out_valid_o;
   logic [DATA_W-1:0]        out_data_o;
   logic [IDX_W-1:0]         out_idx_o;
   logic                     out_ready_i;
   logic                     err_o;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int rr_ptr = 0;
   logic        force_mode = 1'b0;
   logic [31:0] force_val  = 32'h0;
   logic [4:0]  beat_idx_q [$];
   logic [9:0]  beat_dat_q [$];
   int          beat_cyc_q [$];

   rr_req_collector_32 dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .lane_valid_i (lane_valid_i),
      .lane_data_i  (lane_data_i),
      .lane_ready_o (lane_ready_o),
      .req_o        (req_o),
      .grant_i      (grant_i),
      .out_valid_o  (out_valid_o),
      .out_data_o   (out_data_o),
      .out_idx_o    (out_idx_o),
      .out_ready_i  (out_ready_i),
      .err_o        (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] rr_pick(input logic [31:0] r, input int p);
      logic [31:0] g;
      g = 32'h0;
      for (int i = 0; i < 32; i++) begin
         int j;
         j = (p + i) % 32;
         if (r[j] && g == 32'h0) g = 32'h1 << j;
      end
      return g;
   endfunction

   // Grant and output sampling at the falling edge, then step past the rising edge.
   task automatic cycle();
      logic [31:0] g;
      @(negedge clk_i);
      if (force_mode) begin
         grant_i = force_val;
      end else begin
         g = rr_pick(req_o, rr_ptr);
         grant_i = g;
         for (int k = 0; k < 32; k++) if (g[k]) rr_ptr = (k + 1) % 32;
      end
      if (out_valid_o && out_ready_i) begin
         beat_idx_q.push_back(out_idx_o);
         beat_dat_q.push_back(out_data_o);
         beat_cyc_q.push_back(cyc);
      end
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic set_lane(input int k, input logic [9:0] d);
      lane_data_i[k*DATA_W +: DATA_W] = d;
      lane_valid_i[k] = 1'b1;
   endtask

   task automatic clear_beats();
      beat_idx_q.delete();
      beat_dat_q.delete();
      beat_cyc_q.delete();
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      force_mode = 1'b0;
      grant_i = 32'h0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int start_cyc;
      int n_lane_bad;
      int n_data_bad;
      int n_gap_bad;
      int cnt_per [32];
      int last_cyc [32];

      lane_valid_i = '0;
      lane_data_i  = '0;
      grant_i      = '0;
      out_ready_i  = 1'b1;
      do_reset();

      // Reset state
      check_val("rst_req", req_o, 32'h0);
      check_val("rst_ready", lane_ready_o, ALL1);
      check_val("rst_valid", out_valid_o, 1'b0);
      check_val("rst_err", err_o, 1'b0);

      // Single lane 5
      set_lane(5, 10'h2A5);
      cycle();
      lane_valid_i = '0;
      check_val("one_ready_low", lane_ready_o[5], 1'b0);
      check_val("one_req", req_o, 32'h0000_0020);
      cycle();
      check_val("one_ready_back", lane_ready_o[5], 1'b1);
      check_val("one_valid", out_valid_o, 1'b1);
      check_val("one_idx", out_idx_o, 5'd5);
      check_val("one_data", out_data_o, 10'h2A5);
      cycle();
      check_val("one_empty", out_valid_o, 1'b0);
      check_val("one_beats", beat_idx_q.size(), 1);
      check_val("one_beat_idx", beat_idx_q[0], 5'd5);
      check_val("one_beat_data", beat_dat_q[0], 10'h2A5);
      clear_beats();

      // All lanes valid, sustained output
      for (int k = 0; k < 32; k++) set_lane(k, 10'(k * 7 + 3));
      start_cyc = cyc;
      for (int n = 0; n < 120 && beat_idx_q.size() < 64; n++) cycle();
      check_val("all_beats", beat_idx_q.size(), 64);
      check_val("all_cycles", cyc - start_cyc, 66);
      n_lane_bad = 0;
      n_data_bad = 0;
      n_gap_bad  = 0;
      for (int k = 0; k < 32; k++) begin
         cnt_per[k] = 0;
         last_cyc[k] = -1;
      end
      for (int i = 0; i < beat_idx_q.size() && i < 64; i++) begin
         int k;
         k = int'(beat_idx_q[i]);
         cnt_per[k]++;
         if (beat_dat_q[i] !== 10'(k * 7 + 3)) n_data_bad++;
         if (last_cyc[k] >= 0 && beat_cyc_q[i] - last_cyc[k] > 32) n_gap_bad++;
         last_cyc[k] = beat_cyc_q[i];
      end
      for (int k = 0; k < 32; k++) if (cnt_per[k] != 2) n_lane_bad++;
      check_val("all_twice", n_lane_bad, 0);
      check_val("all_data", n_data_bad, 0);
      check_val("all_starve", n_gap_bad, 0);
      lane_valid_i = '0;
      for (int n = 0; n < 100; n++) begin
         if (lane_ready_o == ALL1 && !out_valid_o) break;
         cycle();
      end
      check_val("all_drain_ready", lane_ready_o, ALL1);
      check_val("all_drain_valid", out_valid_o, 1'b0);
      clear_beats();

      // Back-pressure: lanes 3, 6, 20 with output stalled
      rr_ptr = 0;
      out_ready_i = 1'b0;
      set_lane(3, 10'h0C3);
      set_lane(6, 10'h1D6);
      set_lane(20, 10'h314);
      cycle();
      lane_valid_i = '0;
      cycle();
      cycle();
      check_val("bp_req_zero", req_o, 32'h0);
      check_val("bp_pend20", lane_ready_o[20], 1'b0);
      check_val("bp_valid", out_valid_o, 1'b1);
      cycle();
      check_val("bp_req_hold", req_o, 32'h0);
      check_val("bp_head_idx", out_idx_o, 5'd3);
      check_val("bp_head_data", out_data_o, 10'h0C3);
      out_ready_i = 1'b1;
      repeat (5) cycle();
      check_val("bp_beats", beat_idx_q.size(), 3);
      check_val("bp_b0", {beat_idx_q[0], beat_dat_q[0]}, {5'd3, 10'h0C3});
      check_val("bp_b1", {beat_idx_q[1], beat_dat_q[1]}, {5'd6, 10'h1D6});
      check_val("bp_b2", {beat_idx_q[2], beat_dat_q[2]}, {5'd20, 10'h314});
      check_val("bp_empty", out_valid_o, 1'b0);
      clear_beats();

      // Multi-hot grant 0x48 on lanes 3 and 6
      set_lane(3, 10'h111);
      set_lane(6, 10'h222);
      cycle();
      lane_valid_i = '0;
      force_mode = 1'b1;
      force_val = 32'h0000_0048;
      cycle();
      force_mode = 1'b0;
      check_val("mh_err", err_o, ERR_EXP);
      check_val("mh_valid", out_valid_o, !ERR_EXP);
      check_val("mh_pend3", lane_ready_o[3], !ERR_EXP);
      check_val("mh_pend6", lane_ready_o[6], 1'b0);
      rr_ptr = 0;
      repeat (6) cycle();
      check_val("mh_beats", beat_idx_q.size(), 2);
      check_val("mh_b0", {beat_idx_q[0], beat_dat_q[0]}, {5'd3, 10'h111});
      check_val("mh_b1", {beat_idx_q[1], beat_dat_q[1]}, {5'd6, 10'h222});
      check_val("mh_err_sticky", err_o, ERR_EXP);
      clear_beats();

      // Stray grant bit 9 with only lane 2 pending
      do_reset();
      check_val("sg_err_cleared", err_o, 1'b0);
      set_lane(2, 10'h333);
      cycle();
      lane_valid_i = '0;
      force_mode = 1'b1;
      force_val = 32'h0000_0200;
      cycle();
      force_mode = 1'b0;
      check_val("sg_nopush", out_valid_o, 1'b0);
      check_val("sg_pend2", lane_ready_o[2], 1'b0);
      check_val("sg_err", err_o, ERR_EXP);
      repeat (4) cycle();
      check_val("sg_beats", beat_idx_q.size(), 1);
      check_val("sg_b0", {beat_idx_q[0], beat_dat_q[0]}, {5'd2, 10'h333});
      clear_beats();

      // Asynchronous reset with a full FIFO
      out_ready_i = 1'b0;
      set_lane(1, 10'h101);
      set_lane(2, 10'h102);
      set_lane(4, 10'h104);
      cycle();
      lane_valid_i = '0;
      force_mode = 1'b1;
      force_val = 32'h8000_0002;
      cycle();
      force_mode = 1'b0;
      rr_ptr = 0;
      cycle();
      check_val("ar_full_valid", out_valid_o, 1'b1);
      check_val("ar_full_req", req_o, 32'h0);
      check_val("ar_pend4", lane_ready_o[4], 1'b0);
      check_val("ar_err_pre", err_o, ERR_EXP);
      #2;
      rst_i = 1'b1;
      #1;
      check_val("ar_valid", out_valid_o, 1'b0);
      check_val("ar_req", req_o, 32'h0);
      check_val("ar_err", err_o, 1'b0);
      check_val("ar_ready", lane_ready_o, ALL1);
      @(negedge clk_i);
      rst_i = 1'b0;
      out_ready_i = 1'b1;
      cycle();
      check_val("ar_after_valid", out_valid_o, 1'b0);
      check_val("ar_after_beats", beat_idx_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
